// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller.
// Holds the opcode and funct constants, the FSM state enum, the trap-cause
// codes and the encodings of ImmSrc, ALUSrc, ALUControl, READMODE and
// MemWrite. It also holds the per-instruction control bundle that
// instr_decoder produces.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_MEM_WAIT, S_WRITEBACK, S_TRAP
  } state_e;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;
  localparam logic [1:0] TRAP_MISALIGN = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ASRC_REG = 2'b00;
  localparam logic [1:0] ASRC_IMM = 2'b01;
  localparam logic [1:0] ASRC_PC  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  // READMODE reuses the load funct3: bit 2 selects zero extension.
  localparam logic [2:0] RM_B  = 3'b000;
  localparam logic [2:0] RM_H  = 3'b001;
  localparam logic [2:0] RM_W  = 3'b010;
  localparam logic [2:0] RM_BU = 3'b100;
  localparam logic [2:0] RM_HU = 3'b101;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;

  typedef struct packed {
    logic       legal;
    logic       is_branch;
    logic       is_jump;
    logic       is_load;
    logic       is_store;
    logic [2:0] imm_src;
    logic [1:0] alu_src;
    logic [3:0] alu_ctrl;
    logic [2:0] read_mode;
    logic [1:0] store_size;
  } ctrl_t;

  function automatic logic [1:0] store_size(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return MW_BYTE;
      F3_SH:   return MW_HALF;
      F3_SW:   return MW_WORD;
      default: return MW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational per-instruction control decode.
// Ports:
//   instr_i : 32-bit instruction register contents
//   ctrl_o  : legality, instruction class, immediate format, ALU operand
//             select, ALU control, load mode and store size
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_rr;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign alu_rr = {funct3, funct7 == F7_ALT};
  // Register specifiers do not affect control.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    ctrl_o = '0;
    case (opcode)
      OPC_LUI: begin
        ctrl_o.legal    = 1'b1;
        ctrl_o.imm_src  = IMM_U;
        ctrl_o.alu_src  = ASRC_IMM;
        ctrl_o.alu_ctrl = ALU_LUI;
      end
      OPC_AUIPC: begin
        ctrl_o.legal   = 1'b1;
        ctrl_o.imm_src = IMM_U;
        ctrl_o.alu_src = ASRC_PC;
      end
      OPC_JAL: begin
        ctrl_o.legal   = 1'b1;
        ctrl_o.is_jump = 1'b1;
        ctrl_o.imm_src = IMM_J;
        ctrl_o.alu_src = ASRC_PC;
      end
      OPC_JALR: begin
        ctrl_o.legal   = 1'b1;
        ctrl_o.is_jump = 1'b1;
        ctrl_o.imm_src = IMM_I;
        ctrl_o.alu_src = ASRC_IMM;
      end
      OPC_BRANCH: begin
        ctrl_o.legal     = 1'b1;
        ctrl_o.is_branch = 1'b1;
        ctrl_o.imm_src   = IMM_B;
        ctrl_o.alu_src   = ASRC_REG;
      end
      OPC_LOAD: begin
        ctrl_o.legal     = 1'b1;
        ctrl_o.is_load   = 1'b1;
        ctrl_o.imm_src   = IMM_I;
        ctrl_o.alu_src   = ASRC_IMM;
        ctrl_o.read_mode = funct3;
      end
      OPC_STORE: begin
        ctrl_o.legal      = 1'b1;
        ctrl_o.is_store   = 1'b1;
        ctrl_o.imm_src    = IMM_S;
        ctrl_o.alu_src    = ASRC_IMM;
        ctrl_o.store_size = store_size(funct3);
      end
      OPC_OPIMM: begin
        ctrl_o.legal    = 1'b1;
        ctrl_o.imm_src  = IMM_I;
        ctrl_o.alu_src  = ASRC_IMM;
        ctrl_o.alu_ctrl = alu_rr;
      end
      OPC_OP: begin
        ctrl_o.legal    = 1'b1;
        ctrl_o.alu_src  = ASRC_REG;
        ctrl_o.alu_ctrl = alu_rr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory-mapped peripheral channels.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   Instr                 : instruction register contents
//   RF_OUT1, RF_OUT2      : register operands for branch comparison
//   ALUResult             : effective address of loads/stores
//   periph_ready          : per-channel access-complete strobe
//   PCWrite .. ALUControl : datapath controls
//   periph_rd_en/wr_en    : one-hot channel access strobes
//   trap_cause            : 00 none, 01 illegal, 10 timeout, 11 misaligned MMIO
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          N_PERIPH      = 2,
  parameter logic [31:0] PERIPH_BASE   = 32'h00000400,
  parameter int          PERIPH_STRIDE = 4,
  parameter int          TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Instr,
  input  logic [XLEN-1:0]     RF_OUT1,
  input  logic [XLEN-1:0]     RF_OUT2,
  input  logic [XLEN-1:0]     ALUResult,
  input  logic [N_PERIPH-1:0] periph_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                ResultSrc,
  output logic                RF_WD_SRC,
  output logic [1:0]          MemWrite,
  output logic [1:0]          ALUSrc,
  output logic [2:0]          ImmSrc,
  output logic [2:0]          READMODE,
  output logic [3:0]          ALUControl,
  output logic [N_PERIPH-1:0] periph_rd_en,
  output logic [N_PERIPH-1:0] periph_wr_en,
  output logic [1:0]          trap_cause
);

  localparam int              SH         = $clog2(PERIPH_STRIDE);
  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] BASE       = XLEN'(PERIPH_BASE);
  localparam logic [XLEN-1:0] LIMIT      = XLEN'(PERIPH_BASE + 32'(N_PERIPH * PERIPH_STRIDE));
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PERIPH_STRIDE - 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [7:0]      ONE8       = 8'd1;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            cause_q, cause_d;
  logic [2:0]            chan_q, chan_d;
  ctrl_t                 ctrl;
  logic [XLEN-1:0]       offset;
  logic [2:0]            chan;
  logic                  in_window, aligned, taken, ready_sel;
  logic [N_PERIPH-1:0]   strobe;

  instr_decoder u_dec (
    .instr_i (Instr),
    .ctrl_o  (ctrl)
  );

  assign offset    = ALUResult - BASE;
  assign chan      = 3'(offset >> SH);
  assign in_window = (ALUResult >= BASE) && (ALUResult < LIMIT);
  assign aligned   = (offset & ALIGN_MASK) == '0;
  // Channel is latched on entry to MEM_WAIT; ready from any other channel is masked off.
  assign strobe    = N_PERIPH'(ONE8 << chan_q);
  assign ready_sel = |(periph_ready & strobe);

  always_comb begin
    case (Instr[14:12])
      F3_BEQ:  taken = RF_OUT1 == RF_OUT2;
      F3_BNE:  taken = RF_OUT1 != RF_OUT2;
      F3_BLT:  taken = $signed(RF_OUT1) <  $signed(RF_OUT2);
      F3_BGE:  taken = $signed(RF_OUT1) >= $signed(RF_OUT2);
      F3_BLTU: taken = RF_OUT1 <  RF_OUT2;
      F3_BGEU: taken = RF_OUT1 >= RF_OUT2;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= TRAP_NONE;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cause_d      = cause_q;
    chan_d       = chan_q;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    PCSrc        = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 1'b0;
    RF_WD_SRC    = 1'b0;
    MemWrite     = MW_NONE;
    ALUSrc       = '0;
    ImmSrc       = '0;
    READMODE     = '0;
    ALUControl   = '0;
    periph_rd_en = '0;
    periph_wr_en = '0;
    trap_cause   = reset ? TRAP_NONE : cause_q;

    // Reset blanks every output in the cycle it is asserted.
    if (!reset) begin
      if (state_q inside {S_DECODE, S_EXECUTE, S_MEMORY, S_MEM_WAIT, S_WRITEBACK}) begin
        ImmSrc     = ctrl.imm_src;
        ALUSrc     = ctrl.alu_src;
        ALUControl = ctrl.alu_ctrl;
        READMODE   = ctrl.read_mode;
      end
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (ctrl.legal) begin
            state_d = S_EXECUTE;
          end else begin
            cause_d = TRAP_ILLEGAL;
            state_d = S_TRAP;
          end
        end
        S_EXECUTE: begin
          if (ctrl.is_branch) begin
            PCWrite = 1'b1;
            PCSrc   = taken;
            state_d = S_FETCH;
          end else if (ctrl.is_jump) begin
            PCWrite   = 1'b1;
            PCSrc     = 1'b1;
            RegWrite  = 1'b1;
            RF_WD_SRC = 1'b1;
            state_d   = S_FETCH;
          end else if (ctrl.is_load || ctrl.is_store) begin
            state_d = S_MEMORY;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (in_window) begin
            if (!aligned) begin
              cause_d = TRAP_MISALIGN;
              state_d = S_TRAP;
            end else begin
              chan_d  = chan;
              cnt_d   = '0;
              state_d = S_MEM_WAIT;
            end
          end else if (ctrl.is_store) begin
            MemWrite = ctrl.store_size;
            PCWrite  = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
        S_MEM_WAIT: begin
          if (ctrl.is_load) periph_rd_en = strobe;
          else              periph_wr_en = strobe;
          cnt_d = cnt_q + CW'(1);
          // Ready in the final allowed cycle still completes the access.
          if (ready_sel) begin
            if (ctrl.is_store) begin
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else if (cnt_q == CNT_LAST) begin
            cause_d = TRAP_TIMEOUT;
            state_d = S_TRAP;
          end
        end
        S_WRITEBACK: begin
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          ResultSrc = ctrl.is_load;
          state_d   = S_FETCH;
        end
        S_TRAP: ;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [31:0] BASE   = 32'h00000400;
  localparam int          NP     = 2;
  localparam int          STRIDE = 4;
  localparam int          TO     = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = '0, RF_OUT1 = '0, RF_OUT2 = '0, ALUResult = '0;
  logic [1:0]  periph_ready = '0;
  logic        PCWrite, IRWrite, PCSrc, RegWrite, ResultSrc, RF_WD_SRC;
  logic [1:0]  MemWrite, ALUSrc, periph_rd_en, periph_wr_en, trap_cause;
  logic [2:0]  ImmSrc, READMODE;
  logic [3:0]  ALUControl;

  multicycle_controller #(
    .XLEN(32), .N_PERIPH(NP), .PERIPH_BASE(BASE), .PERIPH_STRIDE(STRIDE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2),
    .ALUResult(ALUResult), .periph_ready(periph_ready), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .RF_WD_SRC(RF_WD_SRC), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
    .READMODE(READMODE), .ALUControl(ALUControl), .periph_rd_en(periph_rd_en),
    .periph_wr_en(periph_wr_en), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, pcsrc, regw, ress, wdsrc;
    logic [1:0] memw, alusrc;
    logic [2:0] imm, rm;
    logic [3:0] aluc;
    logic [1:0] rd, wr, cause;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] ins, r1, r2, alu;
    logic [1:0]  rdy;
    out_t        o;
  } step_t;

  step_t tl[$];
  out_t  act, exp_o;
  logic  chk_en = 1'b0;
  string tname = "";
  int    cyc = 0;
  int    checks = 0, passed = 0;

  assign act = {PCWrite, IRWrite, PCSrc, RegWrite, ResultSrc, RF_WD_SRC, MemWrite, ALUSrc,
                ImmSrc, READMODE, ALUControl, periph_rd_en, periph_wr_en, trap_cause};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endtask

  always @(negedge clk) begin
    if (chk_en) check($sformatf("%s@%0d", tname, cyc), {6'd0, act}, {6'd0, exp_o});
  end

  // ---------------- behavioural model ----------------
  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  // Controls visible from DECODE on: immediate format, operand select, ALU op, load mode.
  function automatic out_t dec_fields(input logic [31:0] ins);
    out_t       o;
    logic [3:0] rr;
    o  = '0;
    rr = {ins[14:12], ins[31:25] == 7'b0100000};
    case (ins[6:0])
      7'h37: begin o.imm = 3'd3; o.alusrc = 2'd1; o.aluc = 4'hF; end
      7'h17: begin o.imm = 3'd3; o.alusrc = 2'd2; end
      7'h6F: begin o.imm = 3'd4; o.alusrc = 2'd2; end
      7'h67: begin o.imm = 3'd0; o.alusrc = 2'd1; end
      7'h63: begin o.imm = 3'd2; o.alusrc = 2'd0; end
      7'h03: begin o.imm = 3'd0; o.alusrc = 2'd1; o.rm = ins[14:12]; end
      7'h23: begin o.imm = 3'd1; o.alusrc = 2'd1; end
      7'h13: begin o.imm = 3'd0; o.alusrc = 2'd1; o.aluc = rr; end
      7'h33: begin o.imm = 3'd0; o.alusrc = 2'd0; o.aluc = rr; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic rst, input logic [31:0] ins, r1, r2, alu,
                      input logic [1:0] rdy, input out_t o);
    step_t s;
    s.rst = rst; s.ins = ins; s.r1 = r1; s.r2 = r2; s.alu = alu; s.rdy = rdy; s.o = o;
    tl.push_back(s);
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, '0, '0, '0, '0, 2'b00, '0);
  endtask

  task automatic trap_tail(input logic [31:0] ins, input logic [1:0] cause);
    out_t o;
    o = '0; o.cause = cause;
    for (int i = 0; i < 3; i++) push(1'b0, ins, '0, '0, '0, 2'b00, o);
  endtask

  // Expected cycle-by-cycle timeline of one instruction. rdy_after = number of
  // wait cycles before the selected channel signals ready (-1: never).
  task automatic build(input logic [31:0] ins, r1, r2, alu, input int rdy_after, input bit noise);
    out_t       d, o;
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] oh;
    int         k;
    bit         ld, st;
    d  = dec_fields(ins);
    op = ins[6:0];
    f3 = ins[14:12];
    ld = (op == 7'h03);
    st = (op == 7'h23);
    o = '0; o.irw = 1'b1;
    push(1'b0, ins, r1, r2, alu, 2'b00, o);
    push(1'b0, ins, r1, r2, alu, 2'b00, d);
    if (!is_legal(op)) begin
      trap_tail(ins, 2'b01);
      return;
    end
    if (op == 7'h63) begin
      o = d; o.pcw = 1'b1; o.pcsrc = br_taken(f3, r1, r2);
      push(1'b0, ins, r1, r2, alu, 2'b00, o);
      return;
    end
    if (op == 7'h6F || op == 7'h67) begin
      o = d; o.pcw = 1'b1; o.pcsrc = 1'b1; o.regw = 1'b1; o.wdsrc = 1'b1;
      push(1'b0, ins, r1, r2, alu, 2'b00, o);
      return;
    end
    push(1'b0, ins, r1, r2, alu, 2'b00, d);
    if (!(ld || st)) begin
      o = d; o.regw = 1'b1; o.pcw = 1'b1;
      push(1'b0, ins, r1, r2, alu, 2'b00, o);
      return;
    end
    if (!(alu >= BASE && alu < BASE + NP * STRIDE)) begin
      if (st) begin
        o = d; o.pcw = 1'b1;
        o.memw = (f3 == 3'd0) ? 2'b11 : (f3 == 3'd1) ? 2'b10 : (f3 == 3'd2) ? 2'b01 : 2'b00;
        push(1'b0, ins, r1, r2, alu, 2'b00, o);
      end else begin
        push(1'b0, ins, r1, r2, alu, 2'b00, d);
        o = d; o.regw = 1'b1; o.pcw = 1'b1; o.ress = 1'b1;
        push(1'b0, ins, r1, r2, alu, 2'b00, o);
      end
      return;
    end
    push(1'b0, ins, r1, r2, alu, 2'b00, d);
    if ((alu - BASE) % STRIDE != 0) begin
      trap_tail(ins, 2'b11);
      return;
    end
    k  = int'((alu - BASE) / STRIDE);
    oh = 2'(1 << k);
    for (int c = 0; c < TO; c++) begin
      o = d;
      if (ld) o.rd = oh; else o.wr = oh;
      if (c == rdy_after) begin
        if (st) begin
          o.pcw = 1'b1;
          push(1'b0, ins, r1, r2, alu, oh, o);
        end else begin
          push(1'b0, ins, r1, r2, alu, oh, o);
          o = d; o.regw = 1'b1; o.pcw = 1'b1; o.ress = 1'b1;
          push(1'b0, ins, r1, r2, alu, 2'b00, o);
        end
        return;
      end
      push(1'b0, ins, r1, r2, alu, noise ? (~oh & 2'b11) : 2'b00, o);
    end
    trap_tail(ins, 2'b10);
  endtask

  function automatic int count_strobe(input bit wr, input logic [1:0] v);
    int n = 0;
    foreach (tl[i]) if ((wr ? tl[i].o.wr : tl[i].o.rd) == v) n++;
    return n;
  endfunction

  task automatic play(input string name);
    step_t s;
    tname = name;
    cyc   = 0;
    while (tl.size() > 0) begin
      s = tl.pop_front();
      reset = s.rst; Instr = s.ins; RF_OUT1 = s.r1; RF_OUT2 = s.r2;
      ALUResult = s.alu; periph_ready = s.rdy; exp_o = s.o;
      chk_en = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(posedge clk); #1;
    push_reset(2);
    play("reset");

    build(32'h00500093, 0, 0, 5, -1, 0);              // ADDI x1,x0,5
    check("pin_addi_len", 32'(tl.size()), 4);
    check("pin_addi_irw", 32'(tl[0].o.irw), 1);
    check("pin_addi_wb", 32'({tl[3].o.regw, tl[3].o.pcw}), 32'b11);
    check("pin_addi_aluc", 32'(tl[3].o.aluc), 0);
    play("addi");

    build(32'h00208463, 7, 7, 0, -1, 0);              // BEQ taken
    check("pin_beq_len", 32'(tl.size()), 3);
    check("pin_beq_taken", 32'(tl[2].o.pcsrc), 1);
    play("beq_eq");
    build(32'h00208463, 7, 8, 0, -1, 0);              // BEQ not taken
    check("pin_beq_nt", 32'({tl[2].o.pcw, tl[2].o.pcsrc}), 32'b10);
    play("beq_ne");
    build(32'h0020C463, 32'hFFFFFFFF, 1, 0, -1, 0);   // BLT signed: -1 < 1
    check("pin_blt", 32'(tl[2].o.pcsrc), 1);
    play("blt");
    build(32'h0020E463, 32'hFFFFFFFF, 1, 0, -1, 0);   // BLTU: not taken
    check("pin_bltu", 32'(tl[2].o.pcsrc), 0);
    play("bltu");
    build(32'h0020D463, 1, 32'hFFFFFFFF, 0, -1, 0);   // BGE: 1 >= -1
    play("bge");

    build(32'h402081B3, 0, 0, 0, -1, 0);              // SUB
    check("pin_sub_aluc", 32'(tl[3].o.aluc), 32'b0001);
    play("sub");
    build(32'h123452B7, 0, 0, 0, -1, 0);              // LUI
    check("pin_lui_aluc", 32'(tl[3].o.aluc), 32'hF);
    play("lui");
    build(32'h010000EF, 0, 0, 0, -1, 0);              // JAL
    play("jal");

    build(32'h0020A023, 0, 0, 32'h100, -1, 0);        // SW non-MMIO
    check("pin_sw_len", 32'(tl.size()), 4);
    check("pin_sw_memw", 32'(tl[3].o.memw), 32'b01);
    play("sw_mem");
    build(32'h0020A023, 0, 0, 32'h3FC, -1, 0);        // just below window
    play("sw_below");
    build(32'h0000A183, 0, 0, 32'h100, -1, 0);        // LW non-MMIO
    check("pin_lw_len", 32'(tl.size()), 5);
    play("lw_mem");
    build(32'h0000A183, 0, 0, 32'h408, -1, 0);        // just past window
    check("pin_lw_past_len", 32'(tl.size()), 5);
    play("lw_past");

    build(32'h00208023, 0, 0, 32'h404, 3, 1);         // SB to channel 1
    check("pin_sb_wr", 32'(count_strobe(1, 2'b10)), 4);
    check("pin_sb_len", 32'(tl.size()), 8);
    play("sb_mmio");
    build(32'h0000A183, 0, 0, 32'h400, 0, 0);         // LW ch0, immediate ready
    play("lw_mmio0");
    build(32'h0000A183, 0, 0, 32'h404, TO - 1, 1);    // ready in last allowed cycle
    check("pin_lastrdy_rd", 32'(count_strobe(0, 2'b10)), 255);
    check("pin_lastrdy_ress", 32'(tl[$].o.ress), 1);
    play("lw_lastrdy");

    build(32'h00008183, 0, 0, 32'h400, -1, 0);        // LB, never ready
    check("pin_to_rd", 32'(count_strobe(0, 2'b01)), 255);
    check("pin_to_cause", 32'(tl[$].o.cause), 32'b10);
    push_reset(2);
    play("lb_timeout");

    build(32'h0000A183, 0, 0, 32'h402, -1, 0);        // misaligned MMIO
    check("pin_mis_cause", 32'(tl[$].o.cause), 32'b11);
    check("pin_mis_nostrobe", 32'(count_strobe(0, 2'b01) + count_strobe(0, 2'b10)), 0);
    push_reset(1);
    play("lw_misalign");

    build(32'h00000000, 0, 0, 0, -1, 0);              // illegal opcode
    check("pin_ill_cause", 32'(tl[$].o.cause), 32'b01);
    push_reset(1);
    play("illegal");

    build(32'h0000A183, 0, 0, 32'h404, -1, 0);        // reset during MEM_WAIT
    while (tl.size() > 7) void'(tl.pop_back());
    push_reset(2);
    build(32'h00500093, 0, 0, 5, -1, 0);
    check("pin_rstwait_zero", 32'(tl[7].o), 0);
    check("pin_rstwait_irw", 32'(tl[9].o.irw), 1);
    play("rst_in_wait");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
